// File: rtl/event_timestamp_fifo_pkg.sv
// rtl/event_timestamp_fifo_pkg.sv - shared edge encoding and width helper for the event timestamp FIFO
package event_timestamp_fifo_pkg;

   localparam logic EDGE_FALL = 1'b0;
   localparam logic EDGE_RISE = 1'b1;

   // Smallest r with 2**r >= value; used for pointer and occupancy widths.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/event_timestamp_fifo_sync_fifo_sa.sv
// rtl/event_timestamp_fifo_sync_fifo_sa.sv - generic show-ahead FIFO, head word presented from registered storage
module sync_fifo_sa
   import event_timestamp_fifo_pkg::*;
#(
   parameter int WIDTH = 17,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   clear_i,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic [WIDTH-1:0]       wdata_i,
   output logic [WIDTH-1:0]       rdata_o,
   output logic [clog2(DEPTH):0]  count_o,
   output logic                   full_o,
   output logic                   empty_o
);

   localparam int AW = clog2(DEPTH);
   localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE    = AW'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == FULL_COUNT);
   assign empty_o = (count_q == '0);
   assign do_pop  = pop_i && !empty_o && !clear_i;
   // A pop frees the slot the push needs, so a full FIFO still accepts a simultaneous push.
   assign do_push = push_i && (!full_o || do_pop) && !clear_i;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (do_push) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/event_timestamp_fifo.sv
// rtl/event_timestamp_fifo.sv - tags event pulses with a free-running timestamp and queues them show-ahead
module event_timestamp_fifo
   import event_timestamp_fifo_pkg::*;
#(
   parameter int TS_WIDTH   = 16,
   parameter int DEPTH      = 8,
   parameter int DROP_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   i_Event,
   input  logic                   i_Level,
   input  logic                   i_Clear,
   input  logic                   i_Ready,
   output logic                   o_Valid,
   output logic [TS_WIDTH-1:0]    o_Timestamp,
   output logic                   o_Edge,
   output logic [clog2(DEPTH):0]  o_Count,
   output logic                   o_Overflow,
   output logic [DROP_WIDTH-1:0]  o_Drop_Count
);

   localparam int FW = TS_WIDTH + 1;
   localparam logic [TS_WIDTH-1:0]   TS_ONE   = TS_WIDTH'(1);
   localparam logic [DROP_WIDTH-1:0] DROP_ONE = DROP_WIDTH'(1);

   logic [TS_WIDTH-1:0]   ts_q, ts_d;
   logic                  overflow_q, overflow_d;
   logic [DROP_WIDTH-1:0] drop_q, drop_d;
   logic                  push, pop, drop, full, empty, edge_bit;
   logic [FW-1:0]         wdata, rdata;

   assign edge_bit = i_Level ? EDGE_RISE : EDGE_FALL;
   assign push     = i_Event && !i_Clear;
   assign pop      = i_Ready && !empty && !i_Clear;
   assign drop     = push && full && !pop;
   assign wdata    = {ts_q, edge_bit};

   always_comb begin
      ts_d       = ts_q + TS_ONE;
      overflow_d = overflow_q;
      drop_d     = drop_q;
      if (i_Clear) begin
         ts_d       = '0;
         overflow_d = 1'b0;
         drop_d     = '0;
      end else if (drop) begin
         overflow_d = 1'b1;
         if (drop_q != '1) drop_d = drop_q + DROP_ONE;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ts_q       <= '0;
         overflow_q <= 1'b0;
         drop_q     <= '0;
      end else begin
         ts_q       <= ts_d;
         overflow_q <= overflow_d;
         drop_q     <= drop_d;
      end
   end

   sync_fifo_sa #(
      .WIDTH (FW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .clear_i (i_Clear),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (wdata),
      .rdata_o (rdata),
      .count_o (o_Count),
      .full_o  (full),
      .empty_o (empty)
   );

   assign o_Valid      = !empty;
   assign o_Timestamp  = rdata[FW-1:1];
   assign o_Edge       = rdata[0];
   assign o_Overflow   = overflow_q;
   assign o_Drop_Count = drop_q;

endmodule

// File: tb/tb_event_timestamp_fifo.sv
// tb/tb_event_timestamp_fifo.sv - self-checking bench for event_timestamp_fifo
module tb_event_timestamp_fifo;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        ev = 1'b0, lvl = 1'b0, clr = 1'b0, rdy = 1'b0;
   logic        valid, edge_o, ovf;
   logic [15:0] ts;
   logic [3:0]  cnt;
   logic [7:0]  drops;

   logic        ev4 = 1'b0, lvl4 = 1'b0, clr4 = 1'b0, rdy4 = 1'b0;
   logic        v4, e4, ov4;
   logic [3:0]  ts4;
   logic [3:0]  c4;
   logic [7:0]  dc4;

   int passed = 0;
   int total  = 0;

   typedef struct {
      logic        ev;
      logic        lvl;
      logic        rdy;
      logic        exp_valid;
      logic [15:0] exp_ts;
      logic        exp_edge;
      logic [3:0]  exp_count;
   } vec_t;

   vec_t vec [12];

   event_timestamp_fifo dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .i_Event      (ev),
      .i_Level      (lvl),
      .i_Clear      (clr),
      .i_Ready      (rdy),
      .o_Valid      (valid),
      .o_Timestamp  (ts),
      .o_Edge       (edge_o),
      .o_Count      (cnt),
      .o_Overflow   (ovf),
      .o_Drop_Count (drops)
   );

   event_timestamp_fifo #(.TS_WIDTH(4)) dut4 (
      .clk          (clk),
      .reset_n      (reset_n),
      .i_Event      (ev4),
      .i_Level      (lvl4),
      .i_Clear      (clr4),
      .i_Ready      (rdy4),
      .o_Valid      (v4),
      .o_Timestamp  (ts4),
      .o_Edge       (e4),
      .o_Count      (c4),
      .o_Overflow   (ov4),
      .o_Drop_Count (dc4)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp)
         $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
      else
         passed++;
   endtask

   task automatic do_clear();
      @(negedge clk);
      ev = 1'b0; rdy = 1'b0; clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
   endtask

   initial begin
      for (int r = 0; r < 12; r++)
         vec[r] = '{ev: 1'b0, lvl: 1'b0, rdy: 1'b1, exp_valid: 1'b0,
                    exp_ts: 16'd0, exp_edge: 1'b0, exp_count: 4'd0};
      vec[5].ev  = 1'b1; vec[5].lvl = 1'b1;
      vec[6].exp_valid = 1'b1; vec[6].exp_ts = 16'd5; vec[6].exp_edge = 1'b1; vec[6].exp_count = 4'd1;
      vec[9].ev  = 1'b1; vec[9].lvl = 1'b0;
      vec[10].exp_valid = 1'b1; vec[10].exp_ts = 16'd9; vec[10].exp_edge = 1'b0; vec[10].exp_count = 4'd1;

      // Reset state
      repeat (2) @(negedge clk);
      chk("reset_valid", valid, 0);
      chk("reset_ts", ts, 0);
      chk("reset_edge", edge_o, 0);
      chk("reset_count", cnt, 0);
      chk("reset_ovf", ovf, 0);
      chk("reset_drops", drops, 0);

      // Test 1: row r is the cycle where ts = r
      reset_n = 1'b1;
      for (int r = 0; r < 12; r++) begin
         if (r > 0) @(negedge clk);
         chk($sformatf("t1_valid_r%0d", r), valid, vec[r].exp_valid);
         chk($sformatf("t1_count_r%0d", r), cnt, vec[r].exp_count);
         chk($sformatf("t1_ovf_r%0d", r), ovf, 0);
         if (vec[r].exp_valid) begin
            chk($sformatf("t1_ts_r%0d", r), ts, vec[r].exp_ts);
            chk($sformatf("t1_edge_r%0d", r), edge_o, vec[r].exp_edge);
         end
         ev = vec[r].ev; lvl = vec[r].lvl; rdy = vec[r].rdy;
      end
      @(negedge clk);
      ev = 1'b0;

      // Test 2: 10 events into 8 slots with no consumer
      do_clear();
      for (int k = 0; k < 10; k++) begin
         ev = 1'b1; lvl = k[0];
         @(negedge clk);
      end
      ev = 1'b0;
      chk("t2_count", cnt, 8);
      chk("t2_ovf", ovf, 1);
      chk("t2_drops", drops, 2);
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("t2_valid_%0d", k), valid, 1);
         chk($sformatf("t2_ts_%0d", k), ts, k);
         chk($sformatf("t2_edge_%0d", k), edge_o, k % 2);
         rdy = 1'b1;
         @(negedge clk);
      end
      rdy = 1'b0;
      chk("t2_empty_valid", valid, 0);
      chk("t2_empty_count", cnt, 0);

      // Test 3: push and pop together while full
      do_clear();
      for (int k = 0; k < 8; k++) begin
         ev = 1'b1; lvl = k[0];
         @(negedge clk);
      end
      chk("t3_full_count", cnt, 8);
      ev = 1'b1; lvl = 1'b1; rdy = 1'b1;
      @(negedge clk);
      ev = 1'b0; rdy = 1'b0;
      chk("t3_count", cnt, 8);
      chk("t3_drops", drops, 0);
      chk("t3_ovf", ovf, 0);
      for (int k = 1; k <= 8; k++) begin
         chk($sformatf("t3_ts_%0d", k), ts, k);
         chk($sformatf("t3_edge_%0d", k), edge_o, (k == 8) ? 1 : k % 2);
         rdy = 1'b1;
         @(negedge clk);
      end
      rdy = 1'b0;
      chk("t3_empty_valid", valid, 0);

      // Test 5: drop counter saturation, then clear together with an event
      do_clear();
      for (int k = 0; k < 308; k++) begin
         ev = 1'b1; lvl = 1'b0;
         @(negedge clk);
      end
      ev = 1'b0;
      chk("t5_drops_sat", drops, 255);
      chk("t5_ovf", ovf, 1);
      chk("t5_count", cnt, 8);
      clr = 1'b1; ev = 1'b1; lvl = 1'b1;
      @(negedge clk);
      clr = 1'b0; ev = 1'b0;
      chk("t5_clr_valid", valid, 0);
      chk("t5_clr_count", cnt, 0);
      chk("t5_clr_ovf", ovf, 0);
      chk("t5_clr_drops", drops, 0);
      ev = 1'b1; lvl = 1'b1;
      @(negedge clk);
      ev = 1'b0;
      chk("t5_post_valid", valid, 1);
      chk("t5_post_ts", ts, 0);
      chk("t5_post_count", cnt, 1);

      // Test 4: 4-bit timestamp wraps between the two events
      clr4 = 1'b1;
      @(negedge clk);
      clr4 = 1'b0;
      for (int c = 0; c < 18; c++) begin
         ev4 = (c == 14 || c == 17);
         lvl4 = (c == 14);
         @(negedge clk);
      end
      ev4 = 1'b0;
      chk("t4_count", c4, 2);
      chk("t4_valid", v4, 1);
      chk("t4_ts_first", ts4, 14);
      chk("t4_edge_first", e4, 1);
      rdy4 = 1'b1;
      @(negedge clk);
      rdy4 = 1'b0;
      chk("t4_ts_second", ts4, 1);
      chk("t4_edge_second", e4, 0);
      chk("t4_ovf", ov4, 0);

      // Test 6: asynchronous reset with entries queued
      do_clear();
      for (int k = 0; k < 3; k++) begin
         ev = 1'b1; lvl = 1'b1;
         @(negedge clk);
      end
      ev = 1'b0;
      chk("t6_pre_count", cnt, 3);
      #2;
      reset_n = 1'b0;
      #1;
      chk("t6_rst_valid", valid, 0);
      chk("t6_rst_count", cnt, 0);
      chk("t6_rst_ts", ts, 0);
      chk("t6_rst_edge", edge_o, 0);
      chk("t6_rst_ovf", ovf, 0);
      chk("t6_rst_drops", drops, 0);
      @(negedge clk);
      reset_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         ev = (c == 3); lvl = 1'b1;
         @(negedge clk);
      end
      ev = 1'b0;
      chk("t6_post_valid", valid, 1);
      chk("t6_post_ts", ts, 3);
      chk("t6_post_edge", edge_o, 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
